// File: rtl/accel_bus_sequencer_pkg.sv
// Shared definitions for the accelerator bus sequencer: FSM state encoding
// and the accelerator register map.
package accel_bus_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR_X = 3'd1,
        WR_Y = 3'd2,
        WAIT = 3'd3,
        RD   = 3'd4,
        CAP  = 3'd5,
        HOLD = 3'd6
    } state_t;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RES_W  = 32;

    localparam logic [ADDR_W-1:0] ADDR_X   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_Y   = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_RES = 2'd2;

endpackage

// File: rtl/accel_bus_sequencer.sv
// Accepts an operand pair, writes x and y to the accelerator, optionally waits,
// reads the result back and holds it until the consumer takes it.
module accel_bus_sequencer
    import accel_bus_sequencer_pkg::*;
#(
    parameter int unsigned RD_WAIT = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_data,
    output logic              out_err,
    output logic [15:0]       txn_count,
    output logic [DATA_W-1:0] BUS_D,
    output logic [ADDR_W-1:0] BUS_ADDR,
    output logic              BUS_W,
    output logic              BUS_R,
    output logic              BUS_E,
    input  logic [RES_W-1:0]  BUS_OUT
);

    // Terminal count of the wait counter; unused when RD_WAIT is zero.
    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

    state_t            state;
    state_t            state_next;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_cnt_next;
    logic [DATA_W-1:0] x_lat;
    logic [DATA_W-1:0] y_lat;

    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        case (state)
            IDLE: if (in_valid) state_next = WR_X;
            WR_X: state_next = WR_Y;
            WR_Y: state_next = (RD_WAIT > 0) ? WAIT : RD;
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = RD;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            RD:   state_next = CAP;
            CAP:  state_next = HOLD;
            HOLD: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus signals depend only on registered state and latched operands.
    always_comb begin
        in_ready = (state == IDLE);
        BUS_W    = 1'b0;
        BUS_R    = 1'b0;
        BUS_E    = 1'b0;
        BUS_ADDR = '0;
        BUS_D    = '0;
        case (state)
            WR_X: begin
                BUS_E    = 1'b1;
                BUS_W    = 1'b1;
                BUS_ADDR = ADDR_X;
                BUS_D    = x_lat;
            end
            WR_Y: begin
                BUS_E    = 1'b1;
                BUS_W    = 1'b1;
                BUS_ADDR = ADDR_Y;
                BUS_D    = y_lat;
            end
            WAIT: BUS_E = 1'b1;
            RD: begin
                BUS_E    = 1'b1;
                BUS_R    = 1'b1;
                BUS_ADDR = ADDR_RES;
            end
            CAP: BUS_E = 1'b1;
            default: begin
                BUS_E = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            x_lat     <= '0;
            y_lat     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            txn_count <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state == IDLE && in_valid) begin
                x_lat   <= in_x;
                y_lat   <= in_y;
                out_err <= (in_x == in_y);
            end
            if (state == CAP) begin
                out_data  <= BUS_OUT;
                out_valid <= 1'b1;
                txn_count <= txn_count + 16'd1;
            end
            if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accel_bus_sequencer.sv
// Directed bench for accel_bus_sequencer: two instances (RD_WAIT 0 and 3),
// each driving a behavioural accelerator computing x % (x - y).
module tb_accel_bus_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] in_x      [2];
    logic [15:0] in_y      [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic        out_err   [2];
    logic [15:0] txn_count [2];
    logic [15:0] bus_d     [2];
    logic [1:0]  bus_addr  [2];
    logic        bus_w     [2];
    logic        bus_r     [2];
    logic        bus_e     [2];

    int          checks;
    int          failures;
    logic [15:0] exp_cnt [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] acc_result(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] d;
        d = x - y;
        if (d == 16'd0) return 32'hDEAD_BEEF;
        return {16'd0, x} % {16'd0, d};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [15:0] acc_x;
        logic [15:0] acc_y;
        logic [31:0] acc_out;

        always @(posedge clk) begin
            if (bus_e[gi] && bus_w[gi] && bus_addr[gi] == 2'd0) acc_x <= bus_d[gi];
            if (bus_e[gi] && bus_w[gi] && bus_addr[gi] == 2'd1) acc_y <= bus_d[gi];
            if (bus_e[gi] && bus_r[gi]) acc_out <= acc_result(acc_x, acc_y);
        end

        accel_bus_sequencer #(.RD_WAIT((gi == 0) ? 0 : 3)) u_dut (
            .CLK       (clk),
            .RST_N     (rst_n),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_x      (in_x[gi]),
            .in_y      (in_y[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_data  (out_data[gi]),
            .out_err   (out_err[gi]),
            .txn_count (txn_count[gi]),
            .BUS_D     (bus_d[gi]),
            .BUS_ADDR  (bus_addr[gi]),
            .BUS_W     (bus_w[gi]),
            .BUS_R     (bus_r[gi]),
            .BUS_E     (bus_e[gi]),
            .BUS_OUT   (acc_out)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One full transaction on instance k; hold = cycles out_ready stays low in HOLD.
    task automatic run_txn(input int k, input logic [15:0] x, input logic [15:0] y,
                           input logic [31:0] exp_data, input logic exp_err, input int hold);
        int n, lat, wx, wy, rd, waits;
        logic [31:0] held;
        waits = (k == 0) ? 0 : 3;
        wx = -1; wy = -1; rd = -1; lat = -1;
        @(negedge clk);
        out_ready[k] = (hold == 0);
        in_valid[k]  = 1'b1;
        in_x[k]      = x;
        in_y[k]      = y;
        check("in_ready_idle", 32'(in_ready[k]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        for (n = 0; n < 40; n++) begin
            if (out_valid[k]) begin
                lat = n;
                break;
            end
            check("bus_e_busy", 32'(bus_e[k]), 32'd1);
            check("in_ready_busy", 32'(in_ready[k]), 32'd0);
            check("w_r_exclusive", 32'(bus_w[k] & bus_r[k]), 32'd0);
            if (bus_w[k] && bus_addr[k] == 2'd0) begin
                wx = n;
                check("wr_x_data", 32'(bus_d[k]), 32'(x));
            end else if (bus_w[k] && bus_addr[k] == 2'd1) begin
                wy = n;
                check("wr_y_data", 32'(bus_d[k]), 32'(y));
            end else if (bus_r[k]) begin
                rd = n;
                check("rd_addr", 32'(bus_addr[k]), 32'd2);
                check("rd_data_zero", 32'(bus_d[k]), 32'd0);
            end else begin
                check("no_strobe_bus", {14'd0, bus_d[k], bus_addr[k]}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        exp_cnt[k] = exp_cnt[k] + 16'd1;
        $display("txn inst=%0d x=%0d y=%0d data=%0h err=%0d lat=%0d cnt=%0d",
                 k, x, y, out_data[k], out_err[k], lat, txn_count[k]);
        check("latency", 32'(lat), 32'(4 + waits));
        check("wr_x_cycle", 32'(wx), 32'd0);
        check("wr_y_cycle", 32'(wy), 32'd1);
        check("read_gap", 32'(rd - wy - 1), 32'(waits));
        check("out_data", out_data[k], exp_data);
        check("out_err", 32'(out_err[k]), 32'(exp_err));
        check("txn_count", 32'(txn_count[k]), 32'(exp_cnt[k]));
        check("hold_bus", {27'd0, bus_e[k], bus_w[k], bus_r[k], bus_addr[k]}, 32'd0);
        held = out_data[k];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid[k]), 32'd1);
            check("hold_data", out_data[k], held);
            check("hold_in_ready", 32'(in_ready[k]), 32'd0);
        end
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", 32'(out_valid[k]), 32'd0);
        check("release_in_ready", 32'(in_ready[k]), 32'd1);
        out_ready[k] = 1'b0;
    endtask

    typedef struct {
        int          k;
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] data;
        logic        err;
        int          hold;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{0, 16'd10,    16'd4,  32'h0000_0004, 1'b0, 0};
        vecs[1] = '{0, 16'd7,     16'd7,  32'hDEAD_BEEF, 1'b1, 2};
        vecs[2] = '{0, 16'd100,   16'd30, 32'd30,        1'b0, 10};
        vecs[3] = '{1, 16'd100,   16'd30, 32'd30,        1'b0, 0};
        vecs[4] = '{1, 16'd50,    16'd20, 32'd20,        1'b0, 1};
        vecs[5] = '{0, 16'd65535, 16'd1,  32'd1,         1'b0, 0};
        vecs[6] = '{0, 16'd9,     16'd8,  32'd0,         1'b0, 0};

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            in_x[k]      = '0;
            in_y[k]      = '0;
            out_ready[k] = 1'b0;
            exp_cnt[k]   = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_out_valid", 32'(out_valid[k]), 32'd0);
            check("rst_out_data", out_data[k], 32'd0);
            check("rst_out_err", 32'(out_err[k]), 32'd0);
            check("rst_txn_count", 32'(txn_count[k]), 32'd0);
            check("rst_bus", {27'd0, bus_e[k], bus_w[k], bus_r[k], bus_addr[k]}, 32'd0);
            check("rst_in_ready", 32'(in_ready[k]), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Abandon a transaction while it is writing y.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_x[0]     = 16'd5;
        in_y[0]     = 16'd2;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        check("mid_wr_y_strobe", {30'd0, bus_w[0], bus_addr[0][0]}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_strobes", {29'd0, bus_e[0], bus_w[0], bus_r[0]}, 32'd0);
        check("async_rst_valid", 32'(out_valid[0]), 32'd0);
        check("async_rst_count", 32'(txn_count[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abandon_valid", 32'(out_valid[0]), 32'd0);
        check("abandon_count", 32'(txn_count[0]), 32'd0);
        check("abandon_in_ready", 32'(in_ready[0]), 32'd1);
        $display("txn inst=0 reset during WR_Y, count=%0d", txn_count[0]);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].k, vecs[i].x, vecs[i].y, vecs[i].data, vecs[i].err, vecs[i].hold);
        end

        // Counter wrap: preload 16'hFFFF, then one more transaction.
        @(negedge clk);
        force g_inst[0].u_dut.txn_count = 16'hFFFF;
        #1;
        release g_inst[0].u_dut.txn_count;
        check("preload_count", 32'(txn_count[0]), 32'h0000_FFFF);
        exp_cnt[0] = 16'hFFFF;
        run_txn(0, 16'd3, 16'd1, 32'd1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
